// File: rtl/ysyx_23060072_wb_arbiter.sv
// Round-robin arbiter that shares the single regfile write port among NREQ result
// producers and registers the winning result as a one-cycle write-back beat.
module ysyx_23060072_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic              wb_flag_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_data_o,
  output logic [NREQ-1:0]   wb_src_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   scan_idx;
  logic            grant_any;
  logic [NREQ-1:0] grant_oh;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  // NOTE: every combinational output gets a default before the loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid_i[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    // Nothing is accepted while reset is held, even though valids may be high.
    if (!rst_n) grant_any = 1'b0;
    grant_oh = grant_any ? (NREQ'(1) << grant_idx) : '0;
  end

  assign req_ready_o = grant_oh;
  assign grant_addr  = req_addr_i[grant_idx*AW +: AW];
  assign grant_data  = req_data_i[grant_idx*DW +: DW];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      wb_flag_o <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_src_o  <= '0;
    end else if (grant_any) begin
      rr_ptr    <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
      wb_addr_o <= grant_addr;
      wb_data_o <= grant_data;
      wb_src_o  <= grant_oh;
      // Writes to x0 are accepted from the producer but never reach the regfile.
      wb_flag_o <= |grant_addr;
    end else begin
      wb_flag_o <= 1'b0;
      wb_src_o  <= '0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_wb_arbiter.sv
// Self-checking bench for the write-back arbiter: directed scenarios followed by
// randomized hold-until-accepted traffic compared against a behavioural model.
module tb_ysyx_23060072_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               wb_flag;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic [NREQ-1:0]    wb_src;

  ysyx_23060072_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .wb_flag_o   (wb_flag),
    .wb_addr_o   (wb_addr),
    .wb_data_o   (wb_data),
    .wb_src_o    (wb_src)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: next requester in line and the expected write-back beat.
  int              m_ptr = 0;
  logic            m_flag = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [DW-1:0]   m_data = '0;
  logic [NREQ-1:0] m_src = '0;

  // Pending-request bookkeeping for the random phase.
  int wait_cnt [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    for (int d = 0; d < NREQ; d++)
      if (req_valid[(m_ptr + d) % NREQ]) return (m_ptr + d) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: check ready against the model, clock, then check the registered beat.
  task automatic step(output int g);
    logic [NREQ-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ptr = 0; m_flag = 1'b0; m_addr = '0; m_data = '0; m_src = '0;
    end else if (g >= 0) begin
      m_addr   = req_addr[g*AW +: AW];
      m_data   = req_data[g*DW +: DW];
      m_src    = '0;
      m_src[g] = 1'b1;
      m_flag   = (m_addr != 0);
      m_ptr    = (g + 1) % NREQ;
    end else begin
      m_flag = 1'b0;
      m_src  = '0;
    end
    check("wb_flag", 64'(wb_flag), 64'(m_flag));
    check("wb_addr", 64'(wb_addr), 64'(m_addr));
    check("wb_data", 64'(wb_data), 64'(m_data));
    check("wb_src",  64'(wb_src),  64'(m_src));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [NREQ-1:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // 1: reset held with every requester valid
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'hA000_0000 + i));
    step(g);
    step(g);
    check("t1_ready_in_reset", 64'(req_ready), 64'(0));
    check("t1_flag_in_reset", 64'(wb_flag), 64'(0));
    rst_n = 1'b1;
    step(g);
    check("t1_first_src", 64'(wb_src), 64'(3'b001));

    // 2: single request from req1
    req_valid = '0;
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1 check("t2_ready_same_cycle", 64'(req_ready), 64'(3'b010));
    step(g);
    check("t2_addr", 64'(wb_addr), 64'(5));
    check("t2_data", 64'(wb_data), 64'(32'hDEAD_BEEF));
    check("t2_src", 64'(wb_src), 64'(3'b010));
    check("t2_flag", 64'(wb_flag), 64'(1));
    req_valid = '0;
    step(g);
    check("t2_flag_drops", 64'(wb_flag), 64'(0));

    // 3: bring the pointer back to 0, then all valid for six cycles
    set_req(2, 1'b1, 5'd9, 32'h0000_0009);
    step(g);
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(10 + i), DW'(32'hB000_0000 + i));
    for (int c = 0; c < 6; c++) begin
      step(g);
      check("t3_rr_src", 64'(wb_src), 64'(rr_seq[c]));
      check("t3_no_idle", 64'(wb_flag), 64'(1));
    end

    // 4: wrap from pointer 2 with valids 011
    req_valid = '0;
    set_req(1, 1'b1, 5'd3, 32'h3333_3333);
    step(g);
    set_req(0, 1'b1, 5'd4, 32'h4444_4444);
    step(g);
    check("t4_wrap_src", 64'(wb_src), 64'(3'b001));
    step(g);
    check("t4_next_src", 64'(wb_src), 64'(3'b010));

    // 5: write to x0 is consumed without a regfile write
    req_valid = '0;
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    #1 check("t5_ready", 64'(req_ready), 64'(3'b001));
    step(g);
    check("t5_flag", 64'(wb_flag), 64'(0));
    check("t5_src", 64'(wb_src), 64'(3'b001));

    // 6: asynchronous reset while a beat is on the write port
    req_valid = '0;
    set_req(1, 1'b1, 5'd7, 32'h7777_7777);
    step(g);
    check("t6_beat_live", 64'(wb_flag), 64'(1));
    req_valid = '0;
    set_req(2, 1'b1, 5'd8, 32'h8888_8888);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_flag", 64'(wb_flag), 64'(0));
    check("t6_async_src", 64'(wb_src), 64'(0));
    check("t6_ready_in_reset", 64'(req_ready), 64'(0));
    m_ptr = 0; m_flag = 1'b0; m_addr = '0; m_data = '0; m_src = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(g);
    check("t6_pending_req2", 64'(wb_src), 64'(3'b100));
    check("t6_pending_addr", 64'(wb_addr), 64'(8));

    // Random traffic: each requester holds its request until accepted.
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && ($urandom_range(0, 99) < 60))
          set_req(i, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
      step(g);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          wait_cnt[i]++;
          if (i == g) begin
            check("fairness", 64'(wait_cnt[i] <= NREQ), 64'(1));
            wait_cnt[i] = 0;
            req_valid[i] = 1'b0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
